// File: rtl/ball_engine.sv
// Bouncing-ball object generator: serves from centre, steps once per frame tick,
// clamps on the walls, counts bounces and drives a registered ball-pixel bit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SERVE | ball parked at centre, frame ticks counted until the serve expires
// ST_MOVE  | ball steps both axes on every enabled frame tick
module ball_engine #(
   parameter int SIZE         = 10,
   parameter int X_STEP       = 1,
   parameter int Y_STEP       = 1,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480,
   parameter int UPDATE_LINE  = 491,
   parameter int SERVE_FRAMES = 60,
   parameter int INIT_XDIR    = 1,
   parameter int INIT_YDIR    = 1
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [9:0] i_HSync_Pos,
   input  logic [9:0] i_VSync_Pos,
   input  logic       i_Enable,
   input  logic       i_Serve,
   output logic       o_Video,
   output logic [9:0] o_Xpos,
   output logic [9:0] o_Ypos,
   output logic       o_Hit_X,
   output logic       o_Hit_Y,
   output logic [7:0] o_Bounces,
   output logic       o_Moving
);

   localparam logic [10:0] L_LEFT      = 11'd1;
   localparam logic [10:0] L_RIGHT     = 11'(H_VISIBLE - SIZE + 1);
   localparam logic [10:0] L_TOP       = 11'd1;
   localparam logic [10:0] L_BOTTOM    = 11'(V_VISIBLE - SIZE + 1);
   localparam logic [9:0]  L_LEFT10    = 10'd1;
   localparam logic [9:0]  L_RIGHT10   = 10'(H_VISIBLE - SIZE + 1);
   localparam logic [9:0]  L_TOP10     = 10'd1;
   localparam logic [9:0]  L_BOTTOM10  = 10'(V_VISIBLE - SIZE + 1);
   localparam logic [9:0]  L_XC        = 10'((H_VISIBLE - SIZE) / 2);
   localparam logic [9:0]  L_YC        = 10'((V_VISIBLE - SIZE) / 2);
   localparam logic [10:0] L_XSTEP     = 11'(X_STEP);
   localparam logic [10:0] L_YSTEP     = 11'(Y_STEP);
   localparam logic [9:0]  L_XSTEP10   = 10'(X_STEP);
   localparam logic [9:0]  L_YSTEP10   = 10'(Y_STEP);
   localparam logic [10:0] L_SIZE      = 11'(SIZE);
   localparam logic [9:0]  L_UPD_LINE  = 10'(UPDATE_LINE);
   localparam logic [7:0]  L_SERVE_END = 8'(SERVE_FRAMES - 1);
   localparam logic        L_XDIR0     = (INIT_XDIR != 0);
   localparam logic        L_YDIR0     = (INIT_YDIR != 0);

   typedef enum logic {ST_SERVE, ST_MOVE} state_t;

   state_t      r_state;
   logic        r_xdir;
   logic        r_ydir;
   logic [7:0]  r_frame_cnt;
   logic [9:0]  r_xpos;
   logic [9:0]  r_ypos;
   logic        r_hit_x;
   logic        r_hit_y;
   logic [7:0]  r_bounces;
   logic        r_moving;
   logic        r_video;

   logic        w_tick;
   logic [10:0] w_x_ext;
   logic [10:0] w_y_ext;
   logic [10:0] w_x_fwd;
   logic [10:0] w_y_fwd;
   logic        w_x_hit;
   logic        w_y_hit;
   logic [9:0]  w_x_next;
   logic [9:0]  w_y_next;
   logic [8:0]  w_bounce_sum;
   logic [7:0]  w_bounce_next;
   logic [10:0] w_h_ext;
   logic [10:0] w_v_ext;
   logic        w_in_ball;
   logic        w_serve_done;

   assign w_tick = (i_VSync_Pos == L_UPD_LINE) && (i_HSync_Pos == 10'd1);

   // Wall tests run one bit wider so the forward probe cannot wrap past 1023.
   assign w_x_ext = {1'b0, r_xpos};
   assign w_y_ext = {1'b0, r_ypos};
   assign w_x_fwd = w_x_ext + L_XSTEP;
   assign w_y_fwd = w_y_ext + L_YSTEP;

   assign w_x_hit = r_xdir ? (w_x_fwd >= L_RIGHT) : (w_x_ext <= L_LEFT + L_XSTEP);
   assign w_y_hit = r_ydir ? (w_y_fwd >= L_BOTTOM) : (w_y_ext <= L_TOP + L_YSTEP);

   assign w_x_next = w_x_hit ? (r_xdir ? L_RIGHT10 : L_LEFT10)
                             : (r_xdir ? r_xpos + L_XSTEP10 : r_xpos - L_XSTEP10);
   assign w_y_next = w_y_hit ? (r_ydir ? L_BOTTOM10 : L_TOP10)
                             : (r_ydir ? r_ypos + L_YSTEP10 : r_ypos - L_YSTEP10);

   assign w_bounce_sum  = {1'b0, r_bounces} + {8'd0, w_x_hit} + {8'd0, w_y_hit};
   assign w_bounce_next = w_bounce_sum[8] ? 8'hFF : w_bounce_sum[7:0];

   assign w_h_ext   = {1'b0, i_HSync_Pos};
   assign w_v_ext   = {1'b0, i_VSync_Pos};
   assign w_in_ball = (w_h_ext >= w_x_ext) && (w_h_ext < w_x_ext + L_SIZE) &&
                      (w_v_ext >= w_y_ext) && (w_v_ext < w_y_ext + L_SIZE);

   assign w_serve_done = (r_frame_cnt == L_SERVE_END);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state     <= ST_SERVE;
         r_xdir      <= L_XDIR0;
         r_ydir      <= L_YDIR0;
         r_frame_cnt <= 8'd0;
         r_xpos      <= L_XC;
         r_ypos      <= L_YC;
         r_hit_x     <= 1'b0;
         r_hit_y     <= 1'b0;
         r_bounces   <= 8'd0;
         r_moving    <= 1'b0;
         r_video     <= 1'b0;
      end else begin
         r_hit_x <= 1'b0;
         r_hit_y <= 1'b0;
         r_video <= w_in_ball;
         if (i_Serve) begin
            // Serve beats a coincident tick; flipping xdir alternates the serve side.
            r_state     <= ST_SERVE;
            r_moving    <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_xpos      <= L_XC;
            r_ypos      <= L_YC;
            r_bounces   <= 8'd0;
            r_xdir      <= ~r_xdir;
         end else if (w_tick) begin
            case (r_state)
               ST_SERVE: begin
                  if (w_serve_done) begin
                     r_state     <= ST_MOVE;
                     r_moving    <= 1'b1;
                     r_frame_cnt <= 8'd0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 8'd1;
                  end
               end
               ST_MOVE: begin
                  if (i_Enable) begin
                     r_xpos    <= w_x_next;
                     r_ypos    <= w_y_next;
                     r_hit_x   <= w_x_hit;
                     r_hit_y   <= w_y_hit;
                     r_bounces <= w_bounce_next;
                     if (w_x_hit) r_xdir <= ~r_xdir;
                     if (w_y_hit) r_ydir <= ~r_ydir;
                  end
               end
               default: r_state <= ST_SERVE;
            endcase
         end
      end
   end

   assign o_Video   = r_video;
   assign o_Xpos    = r_xpos;
   assign o_Ypos    = r_ypos;
   assign o_Hit_X   = r_hit_x;
   assign o_Hit_Y   = r_hit_y;
   assign o_Bounces = r_bounces;
   assign o_Moving  = r_moving;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: two parameterisations share one stimulus stream and are
// compared every cycle against an arithmetic model of the ball's motion rules.
module tb_ball_engine;

   logic       clk = 1'b0;
   logic       rst, en, srv;
   logic [9:0] h, v;

   logic       vid0, hx0, hy0, mv0, vid1, hx1, hy1, mv1;
   logic [9:0] x0, y0, x1, y1;
   logic [7:0] b0, b1;

   always #5 clk = ~clk;

   ball_engine u_dut0 (
      .i_Clk(clk), .i_Reset(rst), .i_HSync_Pos(h), .i_VSync_Pos(v),
      .i_Enable(en), .i_Serve(srv), .o_Video(vid0), .o_Xpos(x0), .o_Ypos(y0),
      .o_Hit_X(hx0), .o_Hit_Y(hy0), .o_Bounces(b0), .o_Moving(mv0));

   ball_engine #(.SIZE(10), .X_STEP(3), .Y_STEP(3), .H_VISIBLE(100), .V_VISIBLE(100),
                 .UPDATE_LINE(491), .SERVE_FRAMES(60), .INIT_XDIR(1), .INIT_YDIR(1)) u_dut1 (
      .i_Clk(clk), .i_Reset(rst), .i_HSync_Pos(h), .i_VSync_Pos(v),
      .i_Enable(en), .i_Serve(srv), .o_Video(vid1), .o_Xpos(x1), .o_Ypos(y1),
      .o_Hit_X(hx1), .o_Hit_Y(hy1), .o_Bounces(b1), .o_Moving(mv1));

   int P_SIZE[2] = '{10, 10};
   int P_XS[2]   = '{1, 3};
   int P_YS[2]   = '{1, 3};
   int P_HV[2]   = '{640, 100};
   int P_VV[2]   = '{480, 100};
   int P_SF[2]   = '{60, 60};

   int m_x[2], m_y[2], m_dx[2], m_dy[2], m_mv[2], m_cnt[2], m_b[2];
   int m_hx[2], m_hy[2], m_vid[2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
      end
   endtask

   // One axis move: land on a wall and reverse, or step freely.
   task automatic axis(input int pos, input int dir, input int step, input int lo, input int hi,
                       output int npos, output int ndir, output int hit);
      if (dir == 1 && pos + step >= hi) begin
         npos = hi; ndir = 0; hit = 1;
      end else if (dir == 0 && pos <= lo + step) begin
         npos = lo; ndir = 1; hit = 1;
      end else begin
         npos = (dir == 1) ? pos + step : pos - step;
         ndir = dir; hit = 0;
      end
   endtask

   task automatic model_step();
      int hh, vv, xc, yc, nx, ny, ndx, ndy, hitx, hity;
      hh = int'(h);
      vv = int'(v);
      for (int k = 0; k < 2; k++) begin
         xc = (P_HV[k] - P_SIZE[k]) / 2;
         yc = (P_VV[k] - P_SIZE[k]) / 2;
         m_vid[k] = (!rst && hh >= m_x[k] && hh < m_x[k] + P_SIZE[k] &&
                     vv >= m_y[k] && vv < m_y[k] + P_SIZE[k]) ? 1 : 0;
         m_hx[k] = 0;
         m_hy[k] = 0;
         if (rst) begin
            m_x[k] = xc; m_y[k] = yc; m_dx[k] = 1; m_dy[k] = 1;
            m_mv[k] = 0; m_cnt[k] = 0; m_b[k] = 0;
         end else if (srv) begin
            m_x[k] = xc; m_y[k] = yc; m_dx[k] = 1 - m_dx[k];
            m_mv[k] = 0; m_cnt[k] = 0; m_b[k] = 0;
         end else if (vv == 491 && hh == 1) begin
            if (m_mv[k] == 0) begin
               m_cnt[k]++;
               if (m_cnt[k] == P_SF[k]) begin
                  m_mv[k] = 1; m_cnt[k] = 0;
               end
            end else if (en) begin
               axis(m_x[k], m_dx[k], P_XS[k], 1, P_HV[k] - P_SIZE[k] + 1, nx, ndx, hitx);
               axis(m_y[k], m_dy[k], P_YS[k], 1, P_VV[k] - P_SIZE[k] + 1, ny, ndy, hity);
               m_x[k] = nx; m_y[k] = ny; m_dx[k] = ndx; m_dy[k] = ndy;
               m_hx[k] = hitx; m_hy[k] = hity;
               m_b[k] = (m_b[k] + hitx + hity > 255) ? 255 : m_b[k] + hitx + hity;
            end
         end
      end
   endtask

   task automatic check_all();
      check("xpos", 0, 32'(x0), m_x[0]);   check("xpos", 1, 32'(x1), m_x[1]);
      check("ypos", 0, 32'(y0), m_y[0]);   check("ypos", 1, 32'(y1), m_y[1]);
      check("hit_x", 0, 32'(hx0), m_hx[0]); check("hit_x", 1, 32'(hx1), m_hx[1]);
      check("hit_y", 0, 32'(hy0), m_hy[0]); check("hit_y", 1, 32'(hy1), m_hy[1]);
      check("bounces", 0, 32'(b0), m_b[0]); check("bounces", 1, 32'(b1), m_b[1]);
      check("moving", 0, 32'(mv0), m_mv[0]); check("moving", 1, 32'(mv1), m_mv[1]);
      check("video", 0, 32'(vid0), m_vid[0]); check("video", 1, 32'(vid1), m_vid[1]);
   endtask

   task automatic cyc(input int hh, input int vv, input int ee, input int ss, input int rr);
      rst = (rr != 0);
      en  = (ee != 0);
      srv = (ss != 0);
      h   = hh[9:0];
      v   = vv[9:0];
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n, input int ee);
      for (int i = 0; i < n; i++) begin
         cyc(1, 491, ee, 0, 0);
         cyc(0, 0, ee, 0, 0);
      end
   endtask

   // Literal expectation pinned against both the DUT and the model.
   task automatic lit(input string nm, input int k, input logic [31:0] act, input int mdl, input int exp);
      check({nm, "_dut"}, k, act, exp);
      check({nm, "_model"}, k, mdl, exp);
   endtask

   initial begin
      int r, hh, vv;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
      lit("rst_x", 0, 32'(x0), m_x[0], 315);
      lit("rst_y", 0, 32'(y0), m_y[0], 235);
      lit("rst_moving", 0, 32'(mv0), m_mv[0], 0);
      lit("rst_video", 0, 32'(vid0), m_vid[0], 0);
      lit("rst_x", 1, 32'(x1), m_x[1], 45);

      ticks(59, 1);
      lit("serve59_moving", 0, 32'(mv0), m_mv[0], 0);
      ticks(1, 1);
      lit("serve60_moving", 0, 32'(mv0), m_mv[0], 1);
      lit("serve60_x", 0, 32'(x0), m_x[0], 315);
      cyc(1, 491, 1, 0, 0);
      lit("first_x", 0, 32'(x0), m_x[0], 316);
      lit("first_y", 0, 32'(y0), m_y[0], 236);
      lit("first_x", 1, 32'(x1), m_x[1], 48);
      cyc(0, 0, 1, 0, 0);

      ticks(14, 1);
      lit("pre_corner_x", 1, 32'(x1), m_x[1], 90);
      cyc(1, 491, 1, 0, 0);
      lit("corner_x", 1, 32'(x1), m_x[1], 91);
      lit("corner_y", 1, 32'(y1), m_y[1], 91);
      lit("corner_hx", 1, 32'(hx1), m_hx[1], 1);
      lit("corner_hy", 1, 32'(hy1), m_hy[1], 1);
      lit("corner_bounces", 1, 32'(b1), m_b[1], 2);
      cyc(0, 0, 1, 0, 0);
      lit("pulse_end_hx", 1, 32'(hx1), m_hx[1], 0);
      lit("mid_x", 0, 32'(x0), m_x[0], 331);

      ticks(5, 0);
      lit("pause_x", 1, 32'(x1), m_x[1], 91);
      lit("pause_x", 0, 32'(x0), m_x[0], 331);
      lit("pause_bounces", 1, 32'(b1), m_b[1], 2);
      cyc(1, 491, 1, 0, 0);
      lit("resume_x", 1, 32'(x1), m_x[1], 88);
      lit("resume_x", 0, 32'(x0), m_x[0], 332);
      cyc(0, 0, 1, 0, 0);

      cyc(1, 491, 1, 1, 0);
      lit("serve_x", 0, 32'(x0), m_x[0], 315);
      lit("serve_y", 0, 32'(y0), m_y[0], 235);
      lit("serve_bounces", 1, 32'(b1), m_b[1], 0);
      lit("serve_moving", 0, 32'(mv0), m_mv[0], 0);

      cyc(315, 235, 1, 0, 0); lit("vid_tl", 0, 32'(vid0), m_vid[0], 1);
      cyc(324, 244, 1, 0, 0); lit("vid_br", 0, 32'(vid0), m_vid[0], 1);
      cyc(325, 235, 1, 0, 0); lit("vid_h325", 0, 32'(vid0), m_vid[0], 0);
      cyc(314, 240, 1, 0, 0); lit("vid_h314", 0, 32'(vid0), m_vid[0], 0);
      cyc(320, 245, 1, 0, 0); lit("vid_v245", 0, 32'(vid0), m_vid[0], 0);
      cyc(320, 234, 1, 0, 0); lit("vid_v234", 0, 32'(vid0), m_vid[0], 0);

      ticks(60, 1);
      cyc(1, 491, 1, 0, 0);
      lit("reserve_x", 0, 32'(x0), m_x[0], 314);
      lit("reserve_y", 0, 32'(y0), m_y[0], 236);
      lit("reserve_x", 1, 32'(x1), m_x[1], 48);
      lit("reserve_y", 1, 32'(y1), m_y[1], 42);

      // Long uninterrupted run so the small-field ball saturates its bounce count.
      for (int i = 0; i < 6000; i++) begin
         cyc(1, 491, 1, 0, 0);
         hh = m_x[1] - 2 + int'($urandom_range(0, 13));
         vv = m_y[1] - 2 + int'($urandom_range(0, 13));
         cyc(hh, vv, 1, 0, 0);
      end
      lit("saturated", 1, 32'(b1), m_b[1], 255);

      for (int i = 0; i < 25000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 25) begin
            hh = 1; vv = 491;
         end else if (r < 55) begin
            hh = m_x[0] - 2 + int'($urandom_range(0, 13));
            vv = m_y[0] - 2 + int'($urandom_range(0, 13));
         end else if (r < 85) begin
            hh = m_x[1] - 2 + int'($urandom_range(0, 13));
            vv = m_y[1] - 2 + int'($urandom_range(0, 13));
         end else begin
            hh = int'($urandom_range(0, 1023));
            vv = int'($urandom_range(0, 1023));
         end
         cyc(hh, vv, ($urandom_range(0, 9) != 0) ? 1 : 0,
             ($urandom_range(0, 599) == 0) ? 1 : 0,
             ($urandom_range(0, 3999) == 0) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
